// File: rtl/nonce_tx_arbiter_if.sv
// Handshake bundle between the hasher core array, the nonce arbiter and the
// serial word transmitter.
interface nonce_tx_arbiter_if #(
   parameter int unsigned NUM_CORES  = 4,
   parameter int unsigned DROP_CNT_W = 8
);
   logic [NUM_CORES-1:0]    found_valid;
   logic [32*NUM_CORES-1:0] found_nonce;
   logic                    tx_busy;
   logic [31:0]             tx_word;
   logic                    tx_send;
   logic [NUM_CORES-1:0]    pending;
   logic [DROP_CNT_W-1:0]   drop_count;

   modport master (
      output found_valid, found_nonce, tx_busy,
      input  tx_word, tx_send, pending, drop_count
   );

   modport slave (
      input  found_valid, found_nonce, tx_busy,
      output tx_word, tx_send, pending, drop_count
   );
endinterface

// File: rtl/nonce_tx_arbiter.sv
// Round-robin arbiter feeding golden nonces from NUM_CORES one-deep slots into a
// single serial word transmitter, with a saturating count of overflowed nonces.
module nonce_tx_arbiter #(
   parameter int unsigned NUM_CORES  = 4,
   parameter int unsigned DROP_CNT_W = 8
) (
   input logic               clk,
   input logic               reset,
   nonce_tx_arbiter_if.slave bus
);
   localparam int unsigned PTR_W    = $clog2(NUM_CORES);
   localparam int unsigned DROP_MAX = (1 << DROP_CNT_W) - 1;

   typedef enum logic [1:0] {StIdle, StSend, StWait} state_t;

   state_t                state;
   logic [31:0]           slot [NUM_CORES];
   logic [NUM_CORES-1:0]  pend;
   logic [PTR_W-1:0]      rr_ptr;
   logic [PTR_W-1:0]      grant;
   logic [31:0]           word;
   logic                  send;
   logic [DROP_CNT_W-1:0] drops;

   logic [NUM_CORES-1:0]  clear;
   logic [NUM_CORES-1:0]  drop;
   logic                  found;
   logic [PTR_W-1:0]      winner;
   logic [PTR_W-1:0]      idx;
   logic [DROP_CNT_W-1:0] drops_next;
   int unsigned           ndrop;
   int unsigned           total;

   assign bus.tx_word    = word;
   assign bus.tx_send    = send;
   assign bus.pending    = pend;
   assign bus.drop_count = drops;

   // A slot freed by the transmitter this cycle may be refilled without a drop.
   always_comb begin
      clear = '0;
      if (state == StSend && bus.tx_busy) clear[grant] = 1'b1;
      drop = bus.found_valid & pend & ~clear;
   end

   always_comb begin
      found  = 1'b0;
      winner = rr_ptr;
      idx    = '0;
      for (int k = 1; k <= int'(NUM_CORES); k++) begin
         idx = PTR_W'((int'(rr_ptr) + k) % int'(NUM_CORES));
         if (!found && pend[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      ndrop = 0;
      for (int i = 0; i < int'(NUM_CORES); i++) ndrop += {31'd0, drop[i]};
      total = {{(32 - DROP_CNT_W){1'b0}}, drops} + ndrop;
      if (total > DROP_MAX) total = DROP_MAX;
      drops_next = total[DROP_CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= StIdle;
         pend   <= '0;
         rr_ptr <= PTR_W'(NUM_CORES - 1);
         grant  <= '0;
         word   <= '0;
         send   <= 1'b0;
         drops  <= '0;
         for (int i = 0; i < int'(NUM_CORES); i++) slot[i] <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_CORES); i++) begin
            if (bus.found_valid[i] && (!pend[i] || clear[i])) begin
               slot[i] <= bus.found_nonce[32*i +: 32];
            end
         end
         pend  <= bus.found_valid | (pend & ~clear);
         drops <= drops_next;
         case (state)
            StIdle: begin
               if (found && !bus.tx_busy) begin
                  word   <= slot[winner];
                  send   <= 1'b1;
                  grant  <= winner;
                  rr_ptr <= winner;
                  state  <= StSend;
               end
            end
            StSend: begin
               if (bus.tx_busy) begin
                  send  <= 1'b0;
                  state <= StWait;
               end
            end
            StWait: begin
               if (!bus.tx_busy) state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end
endmodule
